// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with one-deep holding register and misalignment fault
module fetch_unit #(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 16,
    parameter logic [DEPTH-1:0]  RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             pc_load_i,
    input  logic [DEPTH-1:0] pc_target_i,
    output logic             imem_rd_o,
    output logic [DEPTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [DEPTH-1:0] instr_pc_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [DEPTH-1:0] pc_o,
    output logic             busy_o,
    output logic             fault_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state_q;
    logic [DEPTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic [DEPTH-1:0] instr_pc_q;
    logic             instr_valid_q;
    logic             fault_q;
    logic [DEPTH-1:0] hold_pc_d;

    // PC that takes effect when the held word is accepted
    always_comb begin
        hold_pc_d = pc_q;
        if (pc_load_i) begin
            hold_pc_d = pc_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_load_i) begin
                        pc_q <= pc_target_i;
                    end else if (start_i) begin
                        if (pc_q[1:0] == 2'b00) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (pc_load_i) begin
                        // redirect discards the word being read this cycle
                        pc_q <= pc_target_i;
                        if (pc_target_i[1:0] != 2'b00) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end else begin
                        instr_q       <= imem_data_i;
                        instr_pc_q    <= pc_q;
                        pc_q          <= pc_q + DEPTH'(4);
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= hold_pc_d;
                        if (halt_i) begin
                            state_q <= IDLE;
                        end else if (hold_pc_d[1:0] == 2'b00) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (pc_load_i && (pc_target_i[1:0] == 2'b00)) begin
                        pc_q    <= pc_target_i;
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_rd_o     = (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q != IDLE);
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table, reset corner cases and randomized stream check for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, pc_load, instr_ready;
    logic [15:0] pc_target;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic [15:0] pc;
    logic        busy, fault;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[15:2]];

    fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .start_i      (start),
        .halt_i       (halt),
        .pc_load_i    (pc_load),
        .pc_target_i  (pc_target),
        .imem_rd_o    (imem_rd),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .pc_o         (pc),
        .busy_o       (busy),
        .fault_o      (fault)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        bit          start, halt, load, ready;
        logic [15:0] target;
        bit          ev, erd, eb, ef;
        logic [31:0] ei;
        logic [15:0] eipc, epc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit s, input bit h, input bit l, input bit r, input logic [15:0] t,
                       input bit ev, input bit erd, input bit eb, input bit ef,
                       input logic [31:0] ei, input logic [15:0] eipc, input logic [15:0] epc);
        vec_t v;
        v.start = s; v.halt = h; v.load = l; v.ready = r; v.target = t;
        v.ev = ev; v.erd = erd; v.eb = eb; v.ef = ef;
        v.ei = ei; v.eipc = eipc; v.epc = epc;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 1'b0; halt = 1'b0; pc_load = 1'b0; instr_ready = 1'b0; pc_target = 16'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " instr"}, instr, 32'd0);
        chk({tag, " instr_pc"}, {16'd0, instr_pc}, 32'd0);
        chk({tag, " pc"}, {16'd0, pc}, 32'd0);
        chk({tag, " imem_rd"}, {31'd0, imem_rd}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " fault"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [31:0] held_instr;
        logic [13:0] widx;
        bit          held, r, l;
        int          nhs;

        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0]       = 32'h00500093;
        mem[1]       = 32'h00100113;
        mem[2]       = 32'h11111111;
        mem[3]       = 32'h22222222;
        mem[4]       = 32'h44444444;
        mem[16'h3FFF] = 32'hDEADBEEF;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        add(1,0,0,1,16'h0,    0,1,1,0, 32'h0,        16'h0,    16'h0);
        add(0,0,0,1,16'h0,    1,0,1,0, 32'h00500093, 16'h0,    16'h4);
        add(0,0,0,1,16'h0,    0,1,1,0, 32'h00500093, 16'h0,    16'h4);
        add(0,0,0,1,16'h0,    1,0,1,0, 32'h00100113, 16'h4,    16'h8);
        for (int k = 0; k < 5; k++)
            add(1,1,1,0,16'h20, 1,0,1,0, 32'h00100113, 16'h4,  16'h8);
        add(0,0,1,1,16'h10,   0,1,1,0, 32'h00100113, 16'h4,    16'h10);
        add(0,0,0,1,16'h0,    1,0,1,0, 32'h44444444, 16'h10,   16'h14);
        add(0,0,0,1,16'h0,    0,1,1,0, 32'h44444444, 16'h10,   16'h14);
        add(0,0,1,1,16'h08,   0,1,1,0, 32'h44444444, 16'h10,   16'h08);
        add(0,0,0,0,16'h0,    1,0,1,0, 32'h11111111, 16'h08,   16'h0C);
        add(0,0,1,1,16'h06,   0,0,1,1, 32'h11111111, 16'h08,   16'h06);
        add(0,0,1,0,16'h03,   0,0,1,1, 32'h11111111, 16'h08,   16'h06);
        add(1,0,0,0,16'h0,    0,0,1,1, 32'h11111111, 16'h08,   16'h06);
        add(0,0,1,0,16'h08,   0,0,0,0, 32'h11111111, 16'h08,   16'h08);
        add(0,0,1,0,16'hFFFC, 0,0,0,0, 32'h11111111, 16'h08,   16'hFFFC);
        add(1,0,0,0,16'h0,    0,1,1,0, 32'h11111111, 16'h08,   16'hFFFC);
        add(0,1,0,0,16'h0,    1,0,1,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(0,1,0,1,16'h0,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(0,0,0,1,16'h0,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(1,0,0,1,16'h0,    0,1,1,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(0,0,1,1,16'h2,    0,0,1,1, 32'hDEADBEEF, 16'hFFFC, 16'h2);
        add(0,0,1,1,16'h0,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(0,0,1,0,16'h5,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h5);
        add(1,0,0,0,16'h0,    0,0,1,1, 32'hDEADBEEF, 16'hFFFC, 16'h5);
        add(0,0,1,0,16'h0,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h0);
        add(1,0,1,0,16'h4,    0,0,0,0, 32'hDEADBEEF, 16'hFFFC, 16'h4);

        foreach (vq[i]) begin
            start = vq[i].start; halt = vq[i].halt; pc_load = vq[i].load;
            instr_ready = vq[i].ready; pc_target = vq[i].target;
            @(negedge clk);
            chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, {31'd0, vq[i].ev});
            chk($sformatf("v%0d imem_rd", i), {31'd0, imem_rd}, {31'd0, vq[i].erd});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vq[i].eb});
            chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, vq[i].ef});
            chk($sformatf("v%0d instr", i), instr, vq[i].ei);
            chk($sformatf("v%0d instr_pc", i), {16'd0, instr_pc}, {16'd0, vq[i].eipc});
            chk($sformatf("v%0d pc", i), {16'd0, pc}, {16'd0, vq[i].epc});
            if (vq[i].erd)
                chk($sformatf("v%0d imem_addr", i), {16'd0, imem_addr}, {16'd0, vq[i].epc});
        end

        // reset in the middle of HOLD, pc is 4 here
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-rst hold valid", {31'd0, instr_valid}, 32'd1);
        chk("pre-rst hold instr", instr, 32'h00100113);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst mid-hold");
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-rst idle busy", {31'd0, busy}, 32'd0);
        chk("post-rst idle valid", {31'd0, instr_valid}, 32'd0);

        // reset in the middle of FETCH
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre-rst fetch rd", {31'd0, imem_rd}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst mid-fetch");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst fetch valid", {31'd0, instr_valid}, 32'd0);
        chk("post-rst fetch busy", {31'd0, busy}, 32'd0);

        // randomized stream: the model tracks the address of the next word owed to decode
        idle_inputs();
        exp_pc = 16'h0;
        held = 1'b0;
        held_instr = 32'h0;
        nhs = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (imem_rd) chk("rnd imem_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
            if (instr_valid && held) chk("rnd hold stable", instr, held_instr);
            chk("rnd fault", {31'd0, fault}, 32'd0);
            r = ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 9) == 0);
            widx = 14'($urandom);
            instr_ready = r;
            pc_load = l;
            pc_target = {widx, 2'b00};
            if (instr_valid && r) begin
                chk("rnd instr", instr, mem[exp_pc[15:2]]);
                chk("rnd instr_pc", {16'd0, instr_pc}, {16'd0, exp_pc});
                exp_pc = l ? pc_target : exp_pc + 16'd4;
                held = 1'b0;
                nhs++;
            end else if (instr_valid) begin
                held = 1'b1;
                held_instr = instr;
            end else if (l) begin
                exp_pc = pc_target;
            end
            @(negedge clk);
        end
        chk("rnd handshake count", {31'd0, (nhs > 200)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
